// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFF8;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the fetch PC, issues one aligned 64-bit
// I-cache request at a time, writes returned words into the instruction FIFO
// and converts backend redirects into FIFO flushes.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_keep_slot,
    input  logic        fifo_full,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_addr_ok,
    input  logic        ic_data_ok,
    input  logic [31:0] ic_rdata1,
    input  logic [31:0] ic_rdata2,
    output logic        fifo_write_en1,
    output logic        fifo_write_en2,
    output logic [31:0] fifo_write_data1,
    output logic [31:0] fifo_write_data2,
    output logic [31:0] fifo_write_address1,
    output logic [31:0] fifo_write_address2,
    output logic        fifo_flush,
    output logic        fifo_flush_keep_slot
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_redirect_pc;
    logic         w_ic_req;
    logic         w_write;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    // Request is only legal in REQ with FIFO room and no redirect pending.
    assign w_ic_req = !rst && (r_state == REQ) && !fifo_full && !redirect_valid;

    // A response is accepted only in WAIT and only when no redirect overrides it.
    assign w_write  = !rst && (r_state == WAIT) && ic_data_ok && !redirect_valid;

    // State and PC registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // Next-state and next-PC selection; redirects always win over writes.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        unique case (r_state)
            REQ: begin
                if (redirect_valid) begin
                    w_next_pc = w_redirect_pc;
                end else if (w_ic_req && ic_addr_ok) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_next_pc    = w_redirect_pc;
                    w_next_state = ic_data_ok ? REQ : DISCARD;
                end else if (ic_data_ok) begin
                    w_next_pc    = r_pc + (r_pc[2] ? 32'd4 : 32'd8);
                    w_next_state = REQ;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    w_next_pc = w_redirect_pc;
                end
                if (ic_data_ok) begin
                    w_next_state = REQ;
                end
            end
            default: begin
                w_next_state = REQ;
            end
        endcase
    end

    // Output decode: I-cache request and FIFO write ports.
    always_comb begin
        ic_req              = w_ic_req;
        ic_addr             = w_ic_req ? (r_pc & FETCH_ALIGN_MASK) : '0;
        fifo_write_en1      = 1'b0;
        fifo_write_en2      = 1'b0;
        fifo_write_data1    = '0;
        fifo_write_data2    = '0;
        fifo_write_address1 = '0;
        fifo_write_address2 = '0;
        if (w_write) begin
            fifo_write_en1      = 1'b1;
            fifo_write_address1 = r_pc;
            if (r_pc[2]) begin
                // Odd-word PC: only the upper word of the fetch pair is valid.
                fifo_write_data1 = ic_rdata2;
            end else begin
                fifo_write_en2      = 1'b1;
                fifo_write_data1    = ic_rdata1;
                fifo_write_data2    = ic_rdata2;
                fifo_write_address2 = r_pc + 32'd4;
            end
        end
        fifo_flush           = redirect_valid;
        fifo_flush_keep_slot = redirect_valid & redirect_keep_slot;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_keep_slot;
    logic        fifo_full;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_addr_ok;
    logic        ic_data_ok;
    logic [31:0] ic_rdata1;
    logic [31:0] ic_rdata2;
    logic        fifo_write_en1;
    logic        fifo_write_en2;
    logic [31:0] fifo_write_data1;
    logic [31:0] fifo_write_data2;
    logic [31:0] fifo_write_address1;
    logic [31:0] fifo_write_address2;
    logic        fifo_flush;
    logic        fifo_flush_keep_slot;

    int checks;
    int failures;

    fetch_controller #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .redirect_keep_slot   (redirect_keep_slot),
        .fifo_full            (fifo_full),
        .ic_req               (ic_req),
        .ic_addr              (ic_addr),
        .ic_addr_ok           (ic_addr_ok),
        .ic_data_ok           (ic_data_ok),
        .ic_rdata1            (ic_rdata1),
        .ic_rdata2            (ic_rdata2),
        .fifo_write_en1       (fifo_write_en1),
        .fifo_write_en2       (fifo_write_en2),
        .fifo_write_data1     (fifo_write_data1),
        .fifo_write_data2     (fifo_write_data2),
        .fifo_write_address1  (fifo_write_address1),
        .fifo_write_address2  (fifo_write_address2),
        .fifo_flush           (fifo_flush),
        .fifo_flush_keep_slot (fifo_flush_keep_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven, outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        redirect_keep_slot = 1'b0;
        fifo_full = 1'b0;
        ic_addr_ok = 1'b0;
        ic_data_ok = 1'b0;
        ic_rdata1 = '0;
        ic_rdata2 = '0;

        // Reset
        tick();
        tick();
        #1;
        chk("rst_ic_req", {31'd0, ic_req}, 32'd0);
        chk("rst_ic_addr", ic_addr, 32'd0);
        chk("rst_en1", {31'd0, fifo_write_en1}, 32'd0);
        chk("rst_en2", {31'd0, fifo_write_en2}, 32'd0);

        // First fetch: accepted immediately, response two cycles later
        tick();
        rst = 1'b0;
        ic_addr_ok = 1'b1;
        #1;
        chk("t1_ic_req", {31'd0, ic_req}, 32'd1);
        chk("t1_ic_addr", ic_addr, 32'hBFC0_0000);
        tick();
        ic_addr_ok = 1'b0;
        #1;
        chk("t1_wait_req", {31'd0, ic_req}, 32'd0);
        chk("t1_wait_en1", {31'd0, fifo_write_en1}, 32'd0);
        tick();
        ic_data_ok = 1'b1;
        ic_rdata1 = 32'h1111_1111;
        ic_rdata2 = 32'h2222_2222;
        #1;
        chk("t1_en1", {31'd0, fifo_write_en1}, 32'd1);
        chk("t1_en2", {31'd0, fifo_write_en2}, 32'd1);
        chk("t1_data1", fifo_write_data1, 32'h1111_1111);
        chk("t1_data2", fifo_write_data2, 32'h2222_2222);
        chk("t1_addr1", fifo_write_address1, 32'hBFC0_0000);
        chk("t1_addr2", fifo_write_address2, 32'hBFC0_0004);
        tick();
        ic_data_ok = 1'b0;
        #1;
        chk("t1_next_req", {31'd0, ic_req}, 32'd1);
        chk("t1_next_addr", ic_addr, 32'hBFC0_0008);

        // Redirect in REQ to an odd-word target
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0004;
        #1;
        chk("t2_redir_req", {31'd0, ic_req}, 32'd0);
        chk("t2_flush", {31'd0, fifo_flush}, 32'd1);
        chk("t2_flush_keep", {31'd0, fifo_flush_keep_slot}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        ic_addr_ok = 1'b1;
        #1;
        chk("t2_req", {31'd0, ic_req}, 32'd1);
        chk("t2_addr", ic_addr, 32'h8000_0000);
        tick();
        ic_addr_ok = 1'b0;
        ic_data_ok = 1'b1;
        ic_rdata1 = 32'hAAAA_AAAA;
        ic_rdata2 = 32'hBBBB_BBBB;
        #1;
        chk("t2_en1", {31'd0, fifo_write_en1}, 32'd1);
        chk("t2_en2", {31'd0, fifo_write_en2}, 32'd0);
        chk("t2_data1", fifo_write_data1, 32'hBBBB_BBBB);
        chk("t2_addr1", fifo_write_address1, 32'h8000_0004);
        chk("t2_data2", fifo_write_data2, 32'h0);
        chk("t2_addr2", fifo_write_address2, 32'h0);
        tick();
        ic_data_ok = 1'b0;
        #1;
        chk("t2_next_addr", ic_addr, 32'h8000_0008);

        // Redirect with keep_slot while waiting; stale response is dropped
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        redirect_valid = 1'b1;
        redirect_keep_slot = 1'b1;
        redirect_pc = 32'h9000_0010;
        #1;
        chk("t3_flush", {31'd0, fifo_flush}, 32'd1);
        chk("t3_flush_keep", {31'd0, fifo_flush_keep_slot}, 32'd1);
        chk("t3_redir_en1", {31'd0, fifo_write_en1}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_keep_slot = 1'b0;
        #1;
        chk("t3_flush_off", {31'd0, fifo_flush}, 32'd0);
        chk("t3_disc_req", {31'd0, ic_req}, 32'd0);
        tick();
        #1;
        chk("t3_disc_req2", {31'd0, ic_req}, 32'd0);
        tick();
        ic_data_ok = 1'b1;
        ic_rdata1 = 32'hDEAD_0001;
        ic_rdata2 = 32'hDEAD_0002;
        #1;
        chk("t3_drop_en1", {31'd0, fifo_write_en1}, 32'd0);
        chk("t3_drop_en2", {31'd0, fifo_write_en2}, 32'd0);
        tick();
        ic_data_ok = 1'b0;
        #1;
        chk("t3_req", {31'd0, ic_req}, 32'd1);
        chk("t3_addr", ic_addr, 32'h9000_0010);

        // FIFO full holds off requests
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_full_req", {31'd0, ic_req}, 32'd0);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t4_req", {31'd0, ic_req}, 32'd1);
        chk("t4_addr", ic_addr, 32'h9000_0010);

        // Redirect coincident with response: no write, no DISCARD
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        tick();
        ic_data_ok = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hA000_0023;
        #1;
        chk("t5_en1", {31'd0, fifo_write_en1}, 32'd0);
        chk("t5_en2", {31'd0, fifo_write_en2}, 32'd0);
        chk("t5_flush", {31'd0, fifo_flush}, 32'd1);
        tick();
        ic_data_ok = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("t5_req", {31'd0, ic_req}, 32'd1);
        chk("t5_addr", ic_addr, 32'hA000_0020);

        // PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ic_addr_ok = 1'b1;
        #1;
        chk("t6_addr", ic_addr, 32'hFFFF_FFF8);
        tick();
        ic_addr_ok = 1'b0;
        ic_data_ok = 1'b1;
        ic_rdata1 = 32'h0000_0013;
        ic_rdata2 = 32'h0000_0033;
        #1;
        chk("t6_en2", {31'd0, fifo_write_en2}, 32'd1);
        chk("t6_addr1", fifo_write_address1, 32'hFFFF_FFF8);
        chk("t6_addr2", fifo_write_address2, 32'hFFFF_FFFC);
        tick();
        ic_data_ok = 1'b0;
        #1;
        chk("t6_wrap_req", {31'd0, ic_req}, 32'd1);
        chk("t6_wrap_addr", ic_addr, 32'h0000_0000);

        // Response in REQ is ignored
        fifo_full = 1'b1;
        ic_data_ok = 1'b1;
        #1;
        chk("t7_req_ignore_en1", {31'd0, fifo_write_en1}, 32'd0);
        tick();
        fifo_full = 1'b0;
        ic_data_ok = 1'b0;
        #1;
        chk("t7_pc_held", ic_addr, 32'h0000_0000);

        // Reset mid-operation
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        rst = 1'b1;
        ic_data_ok = 1'b1;
        #1;
        chk("t8_rst_en1", {31'd0, fifo_write_en1}, 32'd0);
        chk("t8_rst_req", {31'd0, ic_req}, 32'd0);
        tick();
        rst = 1'b0;
        ic_data_ok = 1'b0;
        #1;
        chk("t8_req", {31'd0, ic_req}, 32'd1);
        chk("t8_addr", ic_addr, 32'hBFC0_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
